// File: rtl/ordered_commit_arbiter.sv
// In-order result commit: an order queue of channel indices selects which
// execution-unit channel may hand its result to the single writeback register.
module ordered_commit_arbiter #(
    parameter  int unsigned NUM_CH     = 4,
    parameter  int unsigned DATA_WIDTH = 64,
    parameter  int unsigned DEPTH      = 8,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ord_tvalid,
    output logic                         ord_tready,
    input  logic [CH_W-1:0]              ord_tdata,
    input  logic [NUM_CH-1:0]            ch_tvalid,
    output logic [NUM_CH-1:0]            ch_tready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_tdata,
    output logic                         out_tvalid,
    input  logic                         out_tready,
    output logic [DATA_WIDTH-1:0]        out_tdata,
    output logic [CH_W-1:0]              out_tid,
    output logic [CNT_W-1:0]             count,
    output logic                         err,
    input  logic                         invalidate
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [CH_W-1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]      r_rd;
    logic [PTR_W-1:0]      r_wr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_out_tvalid;
    logic [DATA_WIDTH-1:0] r_out_tdata;
    logic [CH_W-1:0]       r_out_tid;
    logic                  r_err;

    logic [CH_W-1:0]       w_head;
    logic                  w_nonempty;
    logic                  w_legal;
    logic                  w_load_ok;
    logic                  w_ord_tready;
    logic                  w_push;
    logic                  w_commit;
    logic                  w_drop;
    logic                  w_pop;
    logic [NUM_CH-1:0]     w_ch_tready;
    logic [DATA_WIDTH-1:0] w_sel_data;

    assign w_head       = r_mem[r_rd];
    assign w_nonempty   = (r_count != '0);
    assign w_legal      = (32'(w_head) < 32'(NUM_CH));
    assign w_load_ok    = !r_out_tvalid || out_tready;
    assign w_ord_tready = (r_count != CNT_W'(DEPTH)) && !invalidate;
    assign w_push       = ord_tvalid && w_ord_tready;
    assign w_commit     = |(ch_tvalid & w_ch_tready);
    // Heads naming a nonexistent channel are discarded so the queue cannot wedge
    assign w_drop       = w_nonempty && !w_legal && !invalidate;
    assign w_pop        = w_commit || w_drop;

    // Only the head channel may be ready, and only when the output can load
    always_comb begin
        w_ch_tready = '0;
        w_sel_data  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(w_head) == i) begin
                w_ch_tready[i] = w_nonempty && w_legal && w_load_ok && !invalidate;
                w_sel_data     = ch_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= ord_tdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd         <= '0;
            r_wr         <= '0;
            r_count      <= '0;
            r_out_tvalid <= 1'b0;
            r_out_tdata  <= '0;
            r_out_tid    <= '0;
            r_err        <= 1'b0;
        end else if (invalidate) begin
            r_rd         <= '0;
            r_wr         <= '0;
            r_count      <= '0;
            r_out_tvalid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_commit) begin
                r_out_tvalid <= 1'b1;
                r_out_tdata  <= w_sel_data;
                r_out_tid    <= w_head;
            end else if (out_tready) begin
                r_out_tvalid <= 1'b0;
            end
            r_err <= w_drop;
        end
    end

    assign ord_tready = w_ord_tready;
    assign ch_tready  = w_ch_tready;
    assign out_tvalid = r_out_tvalid;
    assign out_tdata  = r_out_tdata;
    assign out_tid    = r_out_tid;
    assign count      = r_count;
    assign err        = r_err;

endmodule

// File: tb/tb_ordered_commit_arbiter.sv
// Directed bench: a 4-channel instance for ordering/flow control and a
// 3-channel instance for the illegal-index drop path.
module tb_ordered_commit_arbiter;

    localparam int unsigned DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // 4-channel instance
    logic          ord_tvalid = 1'b0;
    logic          ord_tready;
    logic [1:0]    ord_tdata  = '0;
    logic [3:0]    ch_tvalid  = '0;
    logic [3:0]    ch_tready;
    logic [4*DW-1:0] ch_tdata = '0;
    logic          out_tvalid;
    logic          out_tready = 1'b1;
    logic [DW-1:0] out_tdata;
    logic [1:0]    out_tid;
    logic [3:0]    count;
    logic          err;
    logic          invalidate = 1'b0;

    // 3-channel instance
    logic          b_ord_tvalid = 1'b0;
    logic          b_ord_tready;
    logic [1:0]    b_ord_tdata  = '0;
    logic [2:0]    b_ch_tvalid  = '0;
    logic [2:0]    b_ch_tready;
    logic [3*DW-1:0] b_ch_tdata = '0;
    logic          b_out_tvalid;
    logic [DW-1:0] b_out_tdata;
    logic [1:0]    b_out_tid;
    logic [3:0]    b_count;
    logic          b_err;

    int errors = 0;
    int checks = 0;

    ordered_commit_arbiter #(.NUM_CH(4), .DATA_WIDTH(DW), .DEPTH(8)) u_dut (
        .clk(clk), .rst(rst),
        .ord_tvalid(ord_tvalid), .ord_tready(ord_tready), .ord_tdata(ord_tdata),
        .ch_tvalid(ch_tvalid), .ch_tready(ch_tready), .ch_tdata(ch_tdata),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
        .out_tid(out_tid), .count(count), .err(err), .invalidate(invalidate)
    );

    ordered_commit_arbiter #(.NUM_CH(3), .DATA_WIDTH(DW), .DEPTH(8)) u_dut3 (
        .clk(clk), .rst(rst),
        .ord_tvalid(b_ord_tvalid), .ord_tready(b_ord_tready), .ord_tdata(b_ord_tdata),
        .ch_tvalid(b_ch_tvalid), .ch_tready(b_ch_tready), .ch_tdata(b_ch_tdata),
        .out_tvalid(b_out_tvalid), .out_tready(1'b1), .out_tdata(b_out_tdata),
        .out_tid(b_out_tid), .count(b_count), .err(b_err), .invalidate(1'b0)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        check_eq("rst_out_tvalid", 64'(out_tvalid), 64'd0);
        check_eq("rst_out_tdata", out_tdata, 64'd0);
        check_eq("rst_out_tid", 64'(out_tid), 64'd0);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_b_count", 64'(b_count), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Ordering: push 2,0,3; channels 0,3 ready early, channel 2 late
        ch_tdata[0*DW +: DW] = 64'hA000_0000_0000_0000;
        ch_tdata[3*DW +: DW] = 64'hA000_0000_0000_0003;
        ch_tvalid  = 4'b1001;
        ord_tvalid = 1'b1;
        ord_tdata  = 2'd2;
        tick();
        ord_tdata = 2'd0;
        tick();
        ord_tdata = 2'd3;
        tick();
        ord_tvalid = 1'b0;
        check_eq("ord_count3", 64'(count), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check_eq("ord_stall_ready", 64'(ch_tready), 64'b0100);
            check_eq("ord_stall_outv", 64'(out_tvalid), 64'd0);
            tick();
        end
        ch_tdata[2*DW +: DW] = 64'hA000_0000_0000_0002;
        ch_tvalid = 4'b1101;
        tick();
        ch_tvalid = 4'b1001;
        check_eq("ord_o1_v", 64'(out_tvalid), 64'd1);
        check_eq("ord_o1_tid", 64'(out_tid), 64'd2);
        check_eq("ord_o1_data", out_tdata, 64'hA000_0000_0000_0002);
        check_eq("ord_head0_ready", 64'(ch_tready), 64'b0001);
        tick();
        check_eq("ord_o2_tid", 64'(out_tid), 64'd0);
        check_eq("ord_o2_data", out_tdata, 64'hA000_0000_0000_0000);
        tick();
        ch_tvalid = 4'b0000;
        check_eq("ord_o3_tid", 64'(out_tid), 64'd3);
        check_eq("ord_o3_data", out_tdata, 64'hA000_0000_0000_0003);
        check_eq("ord_count0", 64'(count), 64'd0);
        tick();
        check_eq("ord_drain", 64'(out_tvalid), 64'd0);

        // Full queue: 8 pushes, 9th refused, refused again while popping
        ord_tvalid = 1'b1;
        ord_tdata  = 2'd1;
        for (int i = 0; i < 8; i++) tick();
        ord_tdata = 2'd2;
        check_eq("full_count", 64'(count), 64'd8);
        check_eq("full_ordrdy", 64'(ord_tready), 64'd0);
        tick();
        check_eq("full_refused", 64'(count), 64'd8);
        ch_tdata[1*DW +: DW] = 64'hB100;
        ch_tvalid = 4'b0010;
        #1;
        check_eq("full_pop_ordrdy", 64'(ord_tready), 64'd0);
        check_eq("full_pop_chrdy", 64'(ch_tready), 64'b0010);
        tick();
        ch_tvalid = 4'b0000;
        check_eq("full_after_pop", 64'(count), 64'd7);
        check_eq("full_pop_tid", 64'(out_tid), 64'd1);
        check_eq("full_ordrdy_back", 64'(ord_tready), 64'd1);
        tick();
        ord_tvalid = 1'b0;
        check_eq("full_9th_in", 64'(count), 64'd8);
        check_eq("full_outdrain", 64'(out_tvalid), 64'd0);
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        check_eq("full_flushed", 64'(count), 64'd0);

        // Streaming: 16 pushes on channel 1, one result per cycle, pointers wrap twice
        ch_tvalid = 4'b0010;
        for (int cyc = 0; cyc <= 16; cyc++) begin
            ord_tvalid = (cyc < 16);
            ord_tdata  = 2'd1;
            ch_tdata[1*DW +: DW] = 64'h1000 + 64'(cyc) - 64'd1;
            tick();
            check_eq("strm_count", 64'(count), (cyc < 16) ? 64'd1 : 64'd0);
            if (cyc >= 1) begin
                check_eq("strm_outv", 64'(out_tvalid), 64'd1);
                check_eq("strm_data", out_tdata, 64'h1000 + 64'(cyc) - 64'd1);
                check_eq("strm_tid", 64'(out_tid), 64'd1);
            end
        end
        ch_tvalid = 4'b0000;
        tick();
        check_eq("strm_drain", 64'(out_tvalid), 64'd0);

        // Backpressure: hold out_tready low for 4 cycles
        ord_tvalid = 1'b1;
        ord_tdata  = 2'd3;
        tick();
        tick();
        ord_tvalid = 1'b0;
        out_tready = 1'b0;
        ch_tdata[3*DW +: DW] = 64'hB0;
        ch_tvalid = 4'b1000;
        tick();
        ch_tdata[3*DW +: DW] = 64'hB1;
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_chrdy", 64'(ch_tready), 64'd0);
            tick();
            check_eq("bp_outv", 64'(out_tvalid), 64'd1);
            check_eq("bp_data", out_tdata, 64'hB0);
            check_eq("bp_tid", 64'(out_tid), 64'd3);
            check_eq("bp_count", 64'(count), 64'd1);
        end
        out_tready = 1'b1;
        #1;
        check_eq("bp_release_rdy", 64'(ch_tready), 64'b1000);
        tick();
        ch_tvalid = 4'b0000;
        check_eq("bp_next_v", 64'(out_tvalid), 64'd1);
        check_eq("bp_next_data", out_tdata, 64'hB1);
        tick();
        check_eq("bp_drain", 64'(out_tvalid), 64'd0);
        check_eq("bp_count0", 64'(count), 64'd0);

        // Invalidate with 5 queued, output valid, and a push attempt
        ord_tvalid = 1'b1;
        ord_tdata  = 2'd0;
        for (int i = 0; i < 6; i++) tick();
        ord_tvalid = 1'b0;
        out_tready = 1'b0;
        ch_tvalid  = 4'b0001;
        tick();
        ch_tvalid = 4'b0000;
        check_eq("inv_pre_count", 64'(count), 64'd5);
        check_eq("inv_pre_outv", 64'(out_tvalid), 64'd1);
        invalidate = 1'b1;
        ord_tvalid = 1'b1;
        ord_tdata  = 2'd2;
        #1;
        check_eq("inv_ordrdy", 64'(ord_tready), 64'd0);
        tick();
        invalidate = 1'b0;
        ord_tvalid = 1'b0;
        check_eq("inv_count", 64'(count), 64'd0);
        check_eq("inv_outv", 64'(out_tvalid), 64'd0);
        check_eq("inv_err", 64'(err), 64'd0);
        out_tready = 1'b1;
        ord_tvalid = 1'b1;
        #1;
        check_eq("inv_ordrdy_back", 64'(ord_tready), 64'd1);
        tick();
        ord_tvalid = 1'b0;
        check_eq("inv_push_count", 64'(count), 64'd1);
        check_eq("inv_head_rdy", 64'(ch_tready), 64'b0100);
        ch_tdata[2*DW +: DW] = 64'hC2;
        ch_tvalid = 4'b0100;
        tick();
        ch_tvalid = 4'b0000;
        check_eq("inv_commit_tid", 64'(out_tid), 64'd2);
        check_eq("inv_commit_data", out_tdata, 64'hC2);
        tick();

        // Three-channel instance: index 3 is dropped with an err pulse
        b_ch_tdata[1*DW +: DW] = 64'hD1;
        b_ch_tvalid  = 3'b010;
        b_ord_tvalid = 1'b1;
        b_ord_tdata  = 2'd3;
        #1;
        check_eq("ill_empty_rdy", 64'(b_ch_tready), 64'd0);
        tick();
        b_ord_tdata = 2'd1;
        check_eq("ill_head_rdy", 64'(b_ch_tready), 64'd0);
        check_eq("ill_err_pre", 64'(b_err), 64'd0);
        tick();
        b_ord_tvalid = 1'b0;
        check_eq("ill_err", 64'(b_err), 64'd1);
        check_eq("ill_count", 64'(b_count), 64'd1);
        check_eq("ill_outv", 64'(b_out_tvalid), 64'd0);
        check_eq("ill_ch1_rdy", 64'(b_ch_tready), 64'b010);
        tick();
        b_ch_tvalid = 3'b000;
        check_eq("ill_err_once", 64'(b_err), 64'd0);
        check_eq("ill_out_v", 64'(b_out_tvalid), 64'd1);
        check_eq("ill_out_tid", 64'(b_out_tid), 64'd1);
        check_eq("ill_out_data", b_out_tdata, 64'hD1);
        check_eq("ill_count0", 64'(b_count), 64'd0);
        tick();
        check_eq("ill_drain", 64'(b_out_tvalid), 64'd0);

        // Asynchronous reset in the middle of a transaction
        out_tready = 1'b0;
        ch_tdata[0*DW +: DW] = 64'hE0;
        ch_tvalid  = 4'b0001;
        ord_tvalid = 1'b1;
        ord_tdata  = 2'd0;
        tick();
        tick();
        ord_tvalid = 1'b0;
        check_eq("arst_pre_outv", 64'(out_tvalid), 64'd1);
        check_eq("arst_pre_count", 64'(count), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_outv", 64'(out_tvalid), 64'd0);
        check_eq("arst_count", 64'(count), 64'd0);
        check_eq("arst_data", out_tdata, 64'd0);
        check_eq("arst_tid", 64'(out_tid), 64'd0);
        ch_tvalid  = 4'b0000;
        out_tready = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check_eq("arst_after", 64'(count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
